// File: rtl/tc_reg_bus_arbiter_pkg.sv
// tc_reg_bus_arbiter_pkg
//   Shared definitions for the register-bus arbiter: the FSM state encoding
//   and the width of the per-requester register index.
package tc_reg_bus_arbiter_pkg;

    localparam int ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_e;

endpackage

// File: rtl/tc_reg_bus_arbiter_rr_pick.sv
// tc_rr_pick
//   Combinational round-robin picker. Searches req_i starting at ptr_i and
//   wrapping modulo NUM_REQ; the first set bit wins.
//   Ports:
//     req_i    [NUM_REQ-1:0]  request vector
//     ptr_i    [IDX_W-1:0]    search start index (must be < NUM_REQ)
//     onehot_o [NUM_REQ-1:0]  one-hot winner (0 when nothing requests)
//     idx_o    [IDX_W-1:0]    winner index
//     valid_o                 some request is pending
module tc_rr_pick
    import tc_reg_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] onehot_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    int j;

    // Walk the search order backwards so the candidate closest to the
    // pointer is the last one written and therefore wins.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        j        = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (req_i[j]) begin
                onehot_o    = '0;
                onehot_o[j] = 1'b1;
                idx_o       = IDX_W'(j);
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tc_reg_bus_arbiter.sv
// tc_reg_bus_arbiter
//   Round-robin arbiter granting NUM_REQ requesters access to a bank of
//   NUM_REG registers over a shared bus. Each operation takes three cycles:
//   IDLE (sample/latch) -> ACCESS (load/save strobe) -> CAPTURE (ack).
//   Ports:
//     clk, rst                  clock, async active-high reset
//     req/we  [NUM_REQ-1:0]     per-requester request and write flag
//     addr    [NUM_REQ*3-1:0]   per-requester register index
//     wdata   [NUM_REQ*BW-1:0]  per-requester write data
//     gnt/ack [NUM_REQ-1:0]     one-hot grant (ACCESS+CAPTURE) / ack (CAPTURE)
//     err                       out-of-range index, valid with ack
//     rdata   [BW-1:0]          read data, valid with ack
//     reg_load/reg_save         per-register read / write enables
//     bus_out [BW-1:0]          write data to the registers
//     bus_in  [BW-1:0]          shared register output bus
module tc_reg_bus_arbiter
    import tc_reg_bus_arbiter_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int NUM_REQ   = 4,
    parameter int NUM_REG   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             we,
    input  logic [NUM_REQ*ADDR_W-1:0]      addr,
    input  logic [NUM_REQ*BIT_WIDTH-1:0]   wdata,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             ack,
    output logic                           err,
    output logic [BIT_WIDTH-1:0]           rdata,
    output logic [NUM_REG-1:0]             reg_load,
    output logic [NUM_REG-1:0]             reg_save,
    output logic [BIT_WIDTH-1:0]           bus_out,
    input  logic [BIT_WIDTH-1:0]           bus_in
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [BIT_WIDTH-1:0] wdata_q, wdata_d;

    logic [NUM_REQ-1:0]   pick_oh;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_vld;
    logic [NUM_REQ-1:0]   win_oh;
    logic [NUM_REG-1:0]   sel_oh;
    logic                 in_range;

    tc_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .valid_o  (pick_vld)
    );

    // Decodes of the latched winner and register index.
    always_comb begin
        win_oh = '0;
        for (int q = 0; q < NUM_REQ; q++)
            if (idx_q == IDX_W'(q)) win_oh[q] = 1'b1;
        sel_oh = '0;
        for (int r = 0; r < NUM_REG; r++)
            if (addr_q == ADDR_W'(r)) sel_oh[r] = 1'b1;
        in_range = int'(addr_q) < NUM_REG;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // All outputs decode from registered state only, so the async reset of
    // state_q clears every strobe immediately.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        gnt      = '0;
        ack      = '0;
        err      = 1'b0;
        rdata    = '0;
        reg_load = '0;
        reg_save = '0;
        bus_out  = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = ACCESS;
                    idx_d   = pick_idx;
                    we_d    = |(we & pick_oh);
                    addr_d  = addr[pick_idx*ADDR_W +: ADDR_W];
                    wdata_d = wdata[pick_idx*BIT_WIDTH +: BIT_WIDTH];
                    ptr_d   = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                end
            end
            ACCESS: begin
                state_d = CAPTURE;
                gnt     = win_oh;
                if (we_q) begin
                    bus_out = wdata_q;
                    if (in_range) reg_save = sel_oh;
                end else if (in_range) begin
                    reg_load = sel_oh;
                end
            end
            CAPTURE: begin
                state_d = IDLE;
                gnt     = win_oh;
                ack     = win_oh;
                err     = !in_range;
                if (!we_q && in_range) rdata = bus_in;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tc_reg_bus_arbiter.sv
module tb_tc_reg_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  gnt, ack;
    logic        err;
    logic [7:0]  rdata;
    logic [3:0]  reg_load, reg_save;
    logic [7:0]  bus_out;
    logic [7:0]  bus_in = 8'h00;
    logic [7:0]  bank [4] = '{default: 8'h00};

    int checks = 0;
    int errors = 0;

    tc_reg_bus_arbiter #(.BIT_WIDTH(8), .NUM_REQ(4), .NUM_REG(4)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .ack(ack), .err(err), .rdata(rdata),
        .reg_load(reg_load), .reg_save(reg_save), .bus_out(bus_out), .bus_in(bus_in)
    );

    always #5 clk = ~clk;

    // Register bank: writes land on the negedge, reads drive bus_in from
    // the posedge that ends ACCESS.
    always @(negedge clk)
        for (int i = 0; i < 4; i++)
            if (reg_save[i]) bank[i] <= bus_out;

    always @(posedge clk) begin
        bus_in <= 8'h00;
        for (int i = 0; i < 4; i++)
            if (reg_load[i]) bus_in <= bank[i];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req = 4'hF; we = 4'h0; addr = '0; wdata = '0;
        tick(); tick();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_load", 32'(reg_load), 0);
        chk("rst_save", 32'(reg_save), 0);
        chk("rst_busout", 32'(bus_out), 0);

        // Write 0x5A to register 3 from requester 0.
        rst = 1'b0; req = 4'b0001; we = 4'b0001; addr = 12'd3; wdata = 32'h5A;
        tick();
        wdata = 32'hFF;  // must be ignored after latch
        chk("wr_save", 32'(reg_save), 32'h8);
        chk("wr_load", 32'(reg_load), 0);
        chk("wr_busout", 32'(bus_out), 32'h5A);
        chk("wr_gnt", 32'(gnt), 32'h1);
        chk("wr_ack_early", 32'(ack), 0);
        tick();
        chk("wr_ack", 32'(ack), 32'h1);
        chk("wr_err", 32'(err), 0);
        chk("wr_busout_cap", 32'(bus_out), 0);
        req = 4'b0000;
        tick();
        chk("wr_idle_gnt", 32'(gnt), 0);
        chk("wr_bank3", 32'(bank[3]), 32'h5A);

        // Read it back.
        req = 4'b0001; we = 4'b0000; addr = 12'd3;
        tick();
        chk("rd_load", 32'(reg_load), 32'h8);
        chk("rd_save", 32'(reg_save), 0);
        tick();
        chk("rd_ack", 32'(ack), 32'h1);
        chk("rd_rdata", 32'(rdata), 32'h5A);
        chk("rd_err", 32'(err), 0);
        req = 4'b0000;
        tick();
        chk("rd_idle_rdata", 32'(rdata), 0);

        // Out-of-range read (index 6 with 4 registers) from requester 1.
        req = 4'b0010; addr = 12'd6 << 3;
        tick();
        chk("oor_gnt", 32'(gnt), 32'h2);
        chk("oor_load", 32'(reg_load), 0);
        chk("oor_save", 32'(reg_save), 0);
        tick();
        chk("oor_ack", 32'(ack), 32'h2);
        chk("oor_err", 32'(err), 1);
        chk("oor_rdata", 32'(rdata), 0);
        req = 4'b0000;
        tick();
        chk("oor_err_idle", 32'(err), 0);

        // Fresh reset, then all four request continuously for 12 operations.
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'hF; we = 4'h0; addr = {3'd3, 3'd2, 3'd1, 3'd0};
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(1) << (k % 4));
            chk($sformatf("rr_load%0d", k), 32'(reg_load), 32'(1) << (k % 4));
            tick();
            chk($sformatf("rr_ack%0d", k), 32'(ack), 32'(1) << (k % 4));
            chk($sformatf("rr_rdata%0d", k), 32'(rdata), (k % 4 == 3) ? 32'h5A : 32'h0);
            tick();
            chk($sformatf("rr_idle%0d", k), 32'(gnt), 0);
        end
        req = 4'h0;

        // Reset during a write ACCESS from requester 2 (pointer then at 3).
        req = 4'b0100; we = 4'b0100; addr = {3'd3, 3'd2, 3'd1, 3'd0}; wdata = 32'h0033_0000;
        tick();
        chk("abort_save", 32'(reg_save), 32'h4);
        #1 rst = 1'b1;
        #1;
        chk("abort_save_fall", 32'(reg_save), 0);
        chk("abort_busout", 32'(bus_out), 0);
        chk("abort_gnt", 32'(gnt), 0);
        tick();
        chk("abort_noack", 32'(ack), 0);
        chk("abort_bank2", 32'(bank[2]), 0);
        rst = 1'b0; req = 4'b1010; we = 4'b0000;
        tick();
        chk("post_rst_gnt", 32'(gnt), 32'h2);
        tick();
        chk("post_rst_ack", 32'(ack), 32'h2);
        tick();

        // Requester 2 drops req during ACCESS; 3 stays pending.
        req = 4'b1100;
        tick();
        chk("drop_gnt", 32'(gnt), 32'h4);
        req = 4'b1000; addr[8:6] = 3'd1;
        chk("drop_load", 32'(reg_load), 32'h4);
        tick();
        chk("drop_ack", 32'(ack), 32'h4);
        tick();
        chk("drop_idle", 32'(gnt), 0);
        tick();
        chk("next_gnt", 32'(gnt), 32'h8);
        chk("next_load", 32'(reg_load), 32'h8);
        tick();
        chk("next_ack", 32'(ack), 32'h8);
        chk("next_rdata", 32'(rdata), 32'h5A);
        req = 4'b0000;
        tick();
        chk("final_idle", 32'(gnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
